// File: rtl/crc_engine.sv
// Parametrised CRC generator/checker: frame of len beats, MSB-first Galois update,
// result and residue match presented after a one-cycle FIN state.
module crc_engine #(
    parameter int unsigned      CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(32'h1021),
    parameter logic [CRC_W-1:0] INIT    = CRC_W'(32'hFFFF),
    parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(32'h0000),
    parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(32'h0000),
    parameter int unsigned      DATA_W  = 8,
    parameter int unsigned      LEN_W   = 8
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CRC_W-1:0]  crc_o,
    output logic              match_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e             state_q, state_d;
    logic [CRC_W-1:0]   r_q, r_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               match_q, match_d;

    // Folds all DATA_W bits of one beat, MSB first, in a single cycle.
    function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] r_in,
                                              input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = r_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        match_d    = match_q;
        in_ready_o = (state_q == StRun);
        busy_o     = (state_q == StRun);
        done_o     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    r_d = INIT;
                    if (len_i != '0) begin
                        cnt_d   = len_i;
                        state_d = StRun;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRun: begin
                if (abort_i) begin
                    r_d     = INIT;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (in_valid_i) begin
                    r_d   = fold(r_q, in_data_i);
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                // An abort here cancels the result: no pulse, outputs keep the old frame.
                if (abort_i) begin
                    r_d = INIT;
                end else begin
                    done_o  = 1'b1;
                    crc_d   = r_q ^ XOR_OUT;
                    match_d = (r_q == RESIDUE);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            r_q     <= INIT;
            cnt_q   <= '0;
            crc_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            match_q <= match_d;
        end
    end

    assign crc_o   = crc_q;
    assign match_o = match_q;

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: byte-wide and bit-serial instances checked
// against a message-level CRC-16/CCITT-FALSE model.
module tb_crc_engine;

    typedef logic [7:0] bq_t[$];

    localparam logic [15:0] M_POLY = 16'h1021;
    localparam logic [15:0] M_INIT = 16'hFFFF;
    localparam logic [15:0] M_XOUT = 16'h0000;
    localparam logic [15:0] M_RES  = 16'h0000;

    logic clk;
    logic reset_n;

    logic        start8, abort8, valid8, ready8, busy8, done8, match8;
    logic [7:0]  len8, data8;
    logic [15:0] crc8;

    logic        start1, abort1, valid1, ready1, busy1, done1, match1;
    logic [7:0]  len1;
    logic [0:0]  data1;
    logic [15:0] crc1;

    int n_cmp = 0;
    int n_err = 0;

    crc_engine #(.DATA_W(8)) u_dut8 (
        .clock_i(clk), .reset_n_i(reset_n), .start_i(start8), .len_i(len8),
        .abort_i(abort8), .in_valid_i(valid8), .in_ready_o(ready8), .in_data_i(data8),
        .busy_o(busy8), .done_o(done8), .crc_o(crc8), .match_o(match8)
    );

    crc_engine #(.DATA_W(1)) u_dut1 (
        .clock_i(clk), .reset_n_i(reset_n), .start_i(start1), .len_i(len1),
        .abort_i(abort1), .in_valid_i(valid1), .in_ready_o(ready1), .in_data_i(data1),
        .busy_o(busy1), .done_o(done1), .crc_o(crc1), .match_o(match1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Message-level model: register after shifting the whole message in, MSB first.
    function automatic logic [15:0] model_reg(input bq_t msg);
        logic [15:0] r;
        logic        top;
        r = M_INIT;
        foreach (msg[k]) begin
            for (int b = 7; b >= 0; b--) begin
                top = r[15] ^ msg[k][b];
                r   = r << 1;
                if (top) r = r ^ M_POLY;
            end
        end
        return r;
    endfunction

    function automatic bq_t check_msg();
        bq_t q;
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame on the byte-wide instance and checks its handshake timing.
    task automatic run8(input string tag, input bq_t msg, input int gap_pct, input bit noisy,
                        output logic [15:0] c, output logic m);
        int idx;
        int cyc;
        bit acc;
        start8 = 1'b1;
        len8   = 8'(msg.size());
        tick();
        start8 = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < msg.size() && cyc < 5000) begin
            valid8 = ($urandom_range(99) >= gap_pct);
            data8  = valid8 ? msg[idx] : 8'($urandom);
            if (noisy) begin
                start8 = 1'($urandom_range(1));
                len8   = 8'($urandom);
            end
            acc = valid8 && ready8;
            tick();
            cyc++;
            if (acc) idx++;
        end
        valid8 = 1'b0;
        start8 = 1'b0;
        n_cmp++;
        if (idx != msg.size()) begin
            n_err++;
            $display("FAIL %s beats: accepted %0d, required %0d", tag, idx, msg.size());
        end
        n_cmp++;
        if ({done8, ready8, busy8} !== 3'b100) begin
            n_err++;
            $display("FAIL %s fin {done,ready,busy}: got %b, required 100", tag,
                     {done8, ready8, busy8});
        end
        tick();
        n_cmp++;
        if (done8 !== 1'b0) begin
            n_err++;
            $display("FAIL %s done width: got %b, required 0", tag, done8);
        end
        c = crc8;
        m = match8;
    endtask

    // Same for the bit-serial instance; bytes are sent MSB first as single-bit beats.
    task automatic run1(input string tag, input bq_t msg, input int gap_pct,
                        output logic [15:0] c, output logic m);
        bit bits[$];
        int idx;
        int cyc;
        bit acc;
        foreach (msg[k]) for (int b = 7; b >= 0; b--) bits.push_back(msg[k][b]);
        start1 = 1'b1;
        len1   = 8'(bits.size());
        tick();
        start1 = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < bits.size() && cyc < 5000) begin
            valid1 = ($urandom_range(99) >= gap_pct);
            data1  = valid1 ? bits[idx] : 1'($urandom);
            start1 = 1'($urandom_range(1));
            len1   = 8'($urandom);
            acc = valid1 && ready1;
            tick();
            cyc++;
            if (acc) idx++;
        end
        valid1 = 1'b0;
        start1 = 1'b0;
        n_cmp++;
        if (idx != bits.size()) begin
            n_err++;
            $display("FAIL %s beats: accepted %0d, required %0d", tag, idx, bits.size());
        end
        n_cmp++;
        if ({done1, ready1, busy1} !== 3'b100) begin
            n_err++;
            $display("FAIL %s fin {done,ready,busy}: got %b, required 100", tag,
                     {done1, ready1, busy1});
        end
        tick();
        c = crc1;
        m = match1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_cmp++;
        if ({busy8, ready8, done8, crc8, match8, busy1, ready1, done1, crc1, match1} !== '0)
        begin
            n_err++;
            $display("FAIL reset outputs: crc8=%h crc1=%h busy8=%b ready8=%b, required all 0",
                     crc8, crc1, busy8, ready8);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if ({busy8, ready8, done8, crc8, match8} !== '0) begin
            n_err++;
            $display("FAIL idle after reset: crc8=%h busy8=%b, required 0", crc8, busy8);
        end
    endtask

    task automatic test_check_value();
        logic [15:0] c;
        logic m;
        run8("check8", check_msg(), 0, 1'b0, c, m);
        n_cmp++;
        if (c !== 16'h29B1 || m !== 1'b0) begin
            n_err++;
            $display("FAIL check8 crc/match: got %h/%b, required 29b1/0", c, m);
        end
    endtask

    task automatic test_residue();
        bq_t q;
        logic [15:0] c;
        logic m;
        q = check_msg();
        q.push_back(8'h29);
        q.push_back(8'hB1);
        run8("residue", q, 0, 1'b0, c, m);
        n_cmp++;
        if (c !== 16'h0000 || m !== 1'b1) begin
            n_err++;
            $display("FAIL residue crc/match: got %h/%b, required 0000/1", c, m);
        end
        q[2] = q[2] ^ 8'h04;
        run8("corrupt", q, 0, 1'b0, c, m);
        n_cmp++;
        if (m !== 1'b0 || c === 16'h0000 || c !== (model_reg(q) ^ M_XOUT)) begin
            n_err++;
            $display("FAIL corrupt crc/match: got %h/%b, required %h/0", c, m,
                     model_reg(q) ^ M_XOUT);
        end
    endtask

    task automatic test_serial();
        logic [15:0] c;
        logic m;
        run1("serial", check_msg(), 0, c, m);
        n_cmp++;
        if (c !== 16'h29B1) begin
            n_err++;
            $display("FAIL serial crc: got %h, required 29b1", c);
        end
        run1("serial_gaps", check_msg(), 40, c, m);
        n_cmp++;
        if (c !== 16'h29B1 || m !== 1'b0) begin
            n_err++;
            $display("FAIL serial_gaps crc/match: got %h/%b, required 29b1/0", c, m);
        end
    endtask

    task automatic test_zero_len();
        bq_t q;
        logic [15:0] c;
        logic m;
        run8("zero_len", q, 0, 1'b0, c, m);
        n_cmp++;
        if (c !== 16'hFFFF || m !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len crc/match: got %h/%b, required ffff/0", c, m);
        end
    endtask

    task automatic test_start_in_run();
        logic [15:0] c;
        logic m;
        run8("start_in_run", check_msg(), 30, 1'b1, c, m);
        n_cmp++;
        if (c !== 16'h29B1) begin
            n_err++;
            $display("FAIL start_in_run crc: got %h, required 29b1", c);
        end
    endtask

    task automatic test_abort();
        bq_t q;
        logic [15:0] c;
        logic m;
        int dones;
        q = check_msg();
        start8 = 1'b1;
        len8   = 8'd9;
        tick();
        start8 = 1'b0;
        valid8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data8 = q[i];
            tick();
        end
        data8  = q[4];
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        valid8 = 1'b0;
        n_cmp++;
        if ({busy8, ready8} !== 2'b00) begin
            n_err++;
            $display("FAIL abort busy/ready: got %b%b, required 00", busy8, ready8);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dones++;
            tick();
        end
        n_cmp++;
        if (dones != 0 || crc8 !== 16'h29B1) begin
            n_err++;
            $display("FAIL abort no-done/crc: dones=%0d crc=%h, required 0/29b1", dones, crc8);
        end
        // abort together with start in IDLE must swallow the start.
        abort8 = 1'b1;
        start8 = 1'b1;
        tick();
        abort8 = 1'b0;
        start8 = 1'b0;
        n_cmp++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_err++;
            $display("FAIL idle abort+start: busy=%b done=%b, required 0/0", busy8, done8);
        end
        run8("restart", q, 0, 1'b0, c, m);
        n_cmp++;
        if (c !== 16'h29B1) begin
            n_err++;
            $display("FAIL restart crc: got %h, required 29b1", c);
        end
    endtask

    task automatic test_async_reset();
        bq_t q;
        logic [15:0] c;
        logic m;
        q = check_msg();
        start8 = 1'b1;
        len8   = 8'd9;
        tick();
        start8 = 1'b0;
        valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data8 = q[i];
            tick();
        end
        valid8 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, ready8, done8, crc8, match8} !== '0) begin
            n_err++;
            $display("FAIL async reset: busy=%b ready=%b crc=%h, required 0", busy8, ready8,
                     crc8);
        end
        #3;
        reset_n = 1'b1;
        tick();
        run8("post_reset", q, 20, 1'b0, c, m);
        n_cmp++;
        if (c !== 16'h29B1) begin
            n_err++;
            $display("FAIL post_reset crc: got %h, required 29b1", c);
        end
    endtask

    task automatic test_random();
        bq_t q;
        logic [15:0] c;
        logic [15:0] e;
        logic m;
        for (int f = 0; f < 7; f++) begin
            q.delete();
            // Last frame fills the full 255-beat counter range once the CRC is appended.
            for (int i = 0; i < ((f == 6) ? 253 : int'($urandom_range(40, 1))); i++)
                q.push_back(8'($urandom));
            e = model_reg(q) ^ M_XOUT;
            run8("rand", q, 25, 1'b0, c, m);
            n_cmp++;
            if (c !== e || m !== (model_reg(q) == M_RES)) begin
                n_err++;
                $display("FAIL rand[%0d] crc/match: got %h/%b, required %h", f, c, m, e);
            end
            q.push_back(e[15:8]);
            q.push_back(e[7:0]);
            run8("rand_res", q, 25, 1'b0, c, m);
            n_cmp++;
            if (m !== 1'b1 || c !== (M_RES ^ M_XOUT)) begin
                n_err++;
                $display("FAIL rand_res[%0d] len=%0d crc/match: got %h/%b, required %h/1", f,
                         q.size(), c, m, M_RES ^ M_XOUT);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        {start8, abort8, valid8, len8, data8} = '0;
        {start1, abort1, valid1, len1, data1} = '0;
        test_reset();
        test_check_value();
        test_residue();
        test_serial();
        test_zero_len();
        test_start_in_run();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
Name: crc_engine

Overview:
Parametrised CRC generator/checker that succeeds the fixed serial CRC-16 calculator.
- Polynomial, width, init value, output XOR, bits per beat and frame length are all configurable.
- Frame length is supplied at run time per frame; data enters through a valid/ready handshake.
- Sits between link-layer framing and the replay buffer: it computes the CRC for outgoing frames and checks residues on incoming ones.

Parameters:
CRC_W, 16, CRC register width (8..32)
POLY, 16'h1021, generator polynomial without the implicit x^CRC_W term
INIT, 16'hFFFF, register value loaded at frame start
XOR_OUT, 16'h0000, value XORed into the register before it is presented on crc
RESIDUE, 16'h0000, expected register value after a frame that includes its appended CRC
DATA_W, 8, bits consumed per accepted beat (1, 2, 4 or 8), MSB first
LEN_W, 8, width of the beat-count input

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  frame start request, sampled in IDLE only
len  input  LEN_W  number of beats in the frame, sampled with start
abort  input  1  synchronous cancel of the frame in progress
in_valid  input  1  in_data is valid
in_ready  output  1  engine accepts a beat this cycle
in_data  input  DATA_W  data beat; bit DATA_W-1 is processed first
busy  output  1  engine is in RUN
done  output  1  one-cycle pulse when the frame completes
crc  output  CRC_W  final CRC (register XOR XOR_OUT), held until the next done
match  output  1  register equalled RESIDUE at completion, held with crc

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, internal register r=INIT, counter=0.
  - crc=0, match=0, done=0, busy=0, in_ready=0.
- States: IDLE, RUN, FIN.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: load r=INIT and cnt=len, go to RUN.
  - start=1 with len==0: go to FIN with r=INIT.
- RUN:
  - busy=1, in_ready=1.
  - A beat is accepted only when in_valid=1 and in_ready=1. With in_valid=0, r and cnt hold; there is no timeout.
  - Per bit, MSB of the beat first, Galois update: fb = r[CRC_W-1] ^ d; r = (r<<1) ^ (fb ? POLY : 0), truncated to CRC_W.
  - All DATA_W bits are folded combinationally within one cycle.
  - Each accepted beat decrements cnt. Acceptance with cnt==1 goes to FIN; in_ready is 0 from the next cycle.
- FIN (exactly one cycle):
  - done=1, crc<=r^XOR_OUT, match<=(r==RESIDUE). Both outputs update on the FIN clock edge and are visible from the cycle after FIN.
  - Next state is IDLE.
- Latency: done asserts one cycle after the last beat is accepted. crc and match are valid from the cycle after done and stay stable until the next FIN.
- start outside IDLE is ignored; it is not queued.
- start on the same cycle done is high is ignored. A new frame needs start in IDLE, so back-to-back frames have a one-cycle gap.
- abort:
  - In RUN or FIN: go to IDLE, r=INIT, no done pulse; crc and match keep their previous values.
  - abort takes priority over beat acceptance in the same cycle.
  - abort in IDLE has no effect, even together with start; start is ignored that cycle.
- Reset mid-frame: immediate return to IDLE with reset values; the frame is lost.
- len is sampled only at start; later changes have no effect on the current frame.
- Counter width is LEN_W. len = 2^LEN_W-1 (255 beats) is supported without wrap.

Test Plan:
- DATA_W=8, default CRC-16/CCITT-FALSE parameters, len=9, ASCII "123456789" (0x31..0x39) with in_valid held high -> done pulses 1 cycle after the 9th beat; next cycle crc=16'h29B1.
- Same message with len=11 and appended bytes 0x29, 0xB1 -> crc=16'h0000, match=1. Flip one bit of byte 3 -> match=0 and crc≠0.
- DATA_W=1, len=72, same message bit-serial MSB first -> crc=16'h29B1. Pseudo-random in_valid gaps: result unchanged, beat count equals accepted handshakes only.
- start with len=0 -> done one cycle later; next cycle crc=16'hFFFF and match=0. start pulsed during RUN -> no effect on count or result.
- abort after beat 4 of 9 -> no done, crc keeps its prior value, busy=0 next cycle. Immediate restart with the full message -> crc=16'h29B1.
- reset_n pulsed low mid-frame, asynchronously between clock edges -> outputs zero immediately. After release, a full frame yields the correct CRC.
